// File: rtl/emc_arb_seq_pkg.sv
// Shared definitions for the EMC arbiter/sequencer: state encoding,
// idle byte-lane pattern and wait-counter sizing.
package emc_arb_seq_pkg;

  // Width of the per-state wait down-counter (waits are 0..15).
  localparam int WCNT_W = 4;

  // Byte-lane selects with no lane asserted (active low).
  localparam logic [3:0] BLSN_IDLE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RSETUP  = 3'd1,
    ST_RSTROBE = 3'd2,
    ST_WSETUP  = 3'd3,
    ST_WSTROBE = 3'd4,
    ST_WHOLD   = 3'd5,
    ST_TURN    = 3'd6
  } state_e;

  // Counter preload for a phase that must last 'cycles' clock cycles;
  // the phase ends in the cycle where the counter reads zero.
  function automatic logic [WCNT_W-1:0] wcnt_load(input int cycles);
    int v;
    v = cycles - 1;
    return v[WCNT_W-1:0];
  endfunction

endpackage

// File: rtl/emc_arb_seq_rr_arb.sv
// rr_arb: round-robin arbiter. The requester after the last grant has the
// highest priority; the pointer only moves when the grant is consumed.
module rr_arb #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] NW   = (PW+1)'(N);
  localparam logic [PW:0] NWM1 = (PW+1)'(N - 1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   idx;
  logic          found;

  // Scan requesters starting at the pointer and grant the first one found.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= NW) begin
        idx = idx - NW;
      end
      if (!found && req_i[idx[PW-1:0]]) begin
        found = 1'b1;
        gnt_o[idx[PW-1:0]] = 1'b1;
        ptr_d = (idx == NWM1) ? '0 : idx[PW-1:0] + PW'(1);
      end
    end
  end

  // Pointer register: requester 0 first after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/emc_arb_seq.sv
// emc_arb_seq: shares one EMC static-memory bus between NREQ requesters,
// runs one complete read or write cycle per grant and acks with read data.
module emc_arb_seq
  import emc_arb_seq_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int NREQ    = 2,
  parameter int WAITOEN = 0,
  parameter int WAITRD  = 0,
  parameter int WAITWEN = 0,
  parameter int WAITWR  = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] adr_i,
  input  logic [NREQ*DW-1:0] wdat_i,
  input  logic [NREQ*4-1:0]  sel_i,
  output logic [NREQ-1:0]    ack_o,
  output logic [DW-1:0]      rdat_o,
  output logic               busy_o,
  output logic [AW-1:0]      A,
  inout  wire  [DW-1:0]      D,
  output logic [3:0]         BLSN,
  output logic               WEN,
  output logic               OEN,
  output logic               CSN
);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [NREQ-1:0]   gnt, gnt_q, gnt_d, ack_q, ack_d;
  logic              advance;
  logic              g_we, we_q, we_d;
  logic [AW-1:0]     g_adr, adr_q, adr_d;
  logic [DW-1:0]     g_wdat, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]        g_sel, sel_q, sel_d, blsn_q, blsn_d;
  logic              csn_q, csn_d, wen_q, wen_d, oen_q, oen_d, doe_q, doe_d;

  rr_arb #(.N(NREQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .advance_i (advance),
    .gnt_o     (gnt)
  );

  // Select the granted requester's fields for latching.
  always_comb begin
    g_we   = 1'b0;
    g_adr  = '0;
    g_wdat = '0;
    g_sel  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        g_we   = we_i[k];
        g_adr  = adr_i[k*AW +: AW];
        g_wdat = wdat_i[k*DW +: DW];
        g_sel  = sel_i[k*4 +: 4];
      end
    end
  end

  // Next state, wait counter, latched request and registered pin values.
  always_comb begin
    state_d = state_q;
    wcnt_d  = (wcnt_q != '0) ? wcnt_q - WCNT_W'(1) : '0;
    gnt_d   = gnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    ack_d   = '0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          advance = 1'b1;
          gnt_d   = gnt;
          we_d    = g_we;
          adr_d   = g_adr;
          wdat_d  = g_wdat;
          sel_d   = g_sel;
          if (g_we) begin
            state_d = ST_WSETUP;
            wcnt_d  = wcnt_load(WAITWEN + 1);
          end else if (WAITOEN > 0) begin
            state_d = ST_RSETUP;
            wcnt_d  = wcnt_load(WAITOEN);
          end else begin
            state_d = ST_RSTROBE;
            wcnt_d  = wcnt_load(WAITRD + 1);
          end
        end
      end
      ST_RSETUP: begin
        if (wcnt_q == '0) begin
          state_d = ST_RSTROBE;
          wcnt_d  = wcnt_load(WAITRD + 1);
        end
      end
      ST_RSTROBE: begin
        if (wcnt_q == '0) begin
          state_d = ST_TURN;
          rdat_d  = D;
          ack_d   = gnt_q;
        end
      end
      ST_WSETUP: begin
        if (wcnt_q == '0) begin
          state_d = ST_WSTROBE;
          wcnt_d  = wcnt_load(WAITWR + 1);
        end
      end
      ST_WSTROBE: begin
        if (wcnt_q == '0) begin
          state_d = ST_WHOLD;
          wcnt_d  = '0;
        end
      end
      ST_WHOLD: begin
        state_d = ST_TURN;
        ack_d   = gnt_q;
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pins are decoded from the state being entered so they come straight
    // out of flops.
    csn_d  = !(state_d inside {ST_RSETUP, ST_RSTROBE, ST_WSETUP, ST_WSTROBE, ST_WHOLD});
    wen_d  = (state_d != ST_WSTROBE);
    oen_d  = (state_d != ST_RSTROBE);
    blsn_d = (state_d inside {ST_RSETUP, ST_RSTROBE, ST_WSTROBE}) ? ~sel_d : BLSN_IDLE;
    doe_d  = (state_d inside {ST_WSETUP, ST_WSTROBE, ST_WHOLD});
  end

  // State and output registers; reset aborts any cycle in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= '0;
      csn_q   <= 1'b1;
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
      blsn_q  <= BLSN_IDLE;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      csn_q   <= csn_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      blsn_q  <= blsn_d;
      doe_q   <= doe_d;
    end
  end

  assign ack_o  = ack_q;
  assign rdat_o = rdat_q;
  assign busy_o = (state_q != ST_IDLE);
  assign A      = adr_q;
  assign BLSN   = blsn_q;
  assign WEN    = wen_q;
  assign OEN    = oen_q;
  assign CSN    = csn_q;
  assign D      = doe_q ? wdat_q : {DW{1'bz}};

endmodule

// File: tb/tb_emc_arb_seq.sv
// Bench for emc_arb_seq: two instances (all waits zero, and waits 2/3/3/2),
// each with a transfer-level reference model checked every cycle, directed
// timing checks and randomized request traffic.
module tb_emc_arb_seq;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents presented by the bench while OEN is low.
  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] ad);
    if (ad == 8'h07) return 16'hba98;
    return {ad ^ 8'h3c, ~ad};
  endfunction

  task automatic check(input int cfg, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int WO  = (gi == 0) ? 0 : 2;
    localparam int WRD = (gi == 0) ? 0 : 3;
    localparam int WWE = (gi == 0) ? 0 : 3;
    localparam int WWR = (gi == 0) ? 0 : 2;

    logic               rst;
    logic [NREQ-1:0]    req, we, ack;
    logic [NREQ*AW-1:0] adr;
    logic [NREQ*DW-1:0] wdat;
    logic [NREQ*4-1:0]  sel;
    logic [DW-1:0]      rdat;
    logic               busy, wen, oen, csn;
    logic [AW-1:0]      a;
    logic [3:0]         blsn;
    wire  [DW-1:0]      d;
    bit                 done = 1'b0;

    assign d = (!oen) ? rd_pat(a) : {DW{1'bz}};

    emc_arb_seq #(
      .AW(AW), .DW(DW), .NREQ(NREQ),
      .WAITOEN(WO), .WAITRD(WRD), .WAITWEN(WWE), .WAITWR(WWR)
    ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .adr_i(adr),
      .wdat_i(wdat), .sel_i(sel), .ack_o(ack), .rdat_o(rdat), .busy_o(busy),
      .A(a), .D(d), .BLSN(blsn), .WEN(wen), .OEN(oen), .CSN(csn)
    );

    // Reference model: a transfer is a numbered run of cycles after the
    // granting IDLE cycle; each pin follows from its offset in that run.
    bit            mvalid = 1'b0;
    int            phase = 0, last = NREQ - 1, g = 0, len = 0, idx = 0;
    bit            mwe = 1'b0;
    logic [AW-1:0] madr = '0;
    logic [DW-1:0] mwd = '0, e_rdat = '0;
    logic [3:0]    msel = '0, e_blsn = 4'hF;
    logic [NREQ-1:0] e_ack = '0;
    logic          e_csn = 1, e_wen = 1, e_oen = 1, e_drive = 0, e_busy = 0;

    always @(posedge clk) begin
      if (rst) begin
        mvalid = 1'b1;
        phase  = 0;
        last   = NREQ - 1;
        madr   = '0;
      end else if (mvalid) begin
        if (phase == 0) begin
          for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (phase == 0 && req[idx]) begin
              g     = idx;
              last  = idx;
              mwe   = we[idx];
              madr  = adr[idx*AW +: AW];
              mwd   = wdat[idx*DW +: DW];
              msel  = sel[idx*4 +: 4];
              len   = mwe ? (WWE + WWR + 4) : (WO + WRD + 2);
              phase = 1;
            end
          end
        end else if (phase == len) begin
          phase = 0;
        end else begin
          phase++;
        end
      end
      e_csn = 1; e_wen = 1; e_oen = 1; e_blsn = 4'hF; e_ack = '0; e_drive = 0;
      e_busy = (phase != 0);
      if (phase != 0) begin
        if (phase < len) e_csn = 0;
        if (mwe) begin
          if (phase <= WWE + 1) e_drive = 1;
          else if (phase <= WWE + WWR + 2) begin e_drive = 1; e_wen = 0; e_blsn = ~msel; end
          else if (phase < len) e_drive = 1;
        end else begin
          if (phase <= WO) e_blsn = ~msel;
          else if (phase < len) begin e_oen = 0; e_blsn = ~msel; end
        end
        if (phase == len) begin
          e_ack[g] = 1'b1;
          e_rdat   = rd_pat(madr);
        end
      end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
      if (mvalid) begin
        check(gi, "CSN", csn, e_csn);
        check(gi, "WEN", wen, e_wen);
        check(gi, "OEN", oen, e_oen);
        check(gi, "BLSN", blsn, e_blsn);
        check(gi, "A", a, madr);
        check(gi, "ack", ack, e_ack);
        check(gi, "busy", busy, e_busy);
        if (e_drive) check(gi, "D", d, mwd);
        if (|e_ack && !mwe) check(gi, "rdat", rdat, e_rdat);
        if (|e_ack)
          $display("cfg%0d xfer req%0d %s adr=%02h data=%04h", gi, g, mwe ? "wr" : "rd",
                   madr, mwe ? mwd : rdat);
      end
    end

    task automatic xfer(input int k, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                        input logic [3:0] s, output int ac, output int cf, output int wf,
                        output int wl, output int ol, output logic [3:0] bl,
                        output logic [DW-1:0] dv, output logic [DW-1:0] rd);
      int n;
      ac = 0; cf = 0; wf = 0; wl = 0; ol = 0; bl = '0; dv = '0; rd = '0; n = 1;
      we[k] = w; adr[k*AW +: AW] = ad; wdat[k*DW +: DW] = wd; sel[k*4 +: 4] = s;
      req[k] = 1'b1;
      while (ac == 0 && n < 60) begin
        @(posedge clk); #2; n++;
        if (!csn && cf == 0) cf = n;
        if (!wen) begin
          if (wf == 0) wf = n;
          wl++; bl = blsn; dv = d;
        end
        if (!oen) ol++;
        if (ack[k]) begin
          ac = n; rd = rdat; req[k] = 1'b0;
        end
      end
    endtask

    initial begin
      int ac, cf, wf, wl, ol, n, hi, min_gap, no_ack;
      bit seen_low;
      logic [3:0] bl;
      logic [DW-1:0] dv, rd;
      int order[$];

      rst = 1'b1; req = '0; we = '0; adr = '0; wdat = '0; sel = '0;
      repeat (2) @(posedge clk);
      #2;
      check(gi, "rst_CSN", csn, 1);
      check(gi, "rst_WEN", wen, 1);
      check(gi, "rst_OEN", oen, 1);
      check(gi, "rst_BLSN", blsn, 4'hF);
      check(gi, "rst_A", a, 0);
      check(gi, "rst_ack", ack, 0);
      check(gi, "rst_rdat", rdat, 0);
      check(gi, "rst_busy", busy, 0);
      rst = 1'b0;

      // Single write from requester 0.
      xfer(0, 1'b1, 8'ha5, 16'habcd, 4'h3, ac, cf, wf, wl, ol, bl, dv, rd);
      check(gi, "wr_ack_cycle", ac, (gi == 0) ? 5 : 10);
      check(gi, "wr_wen_len", wl, (gi == 0) ? 1 : 3);
      check(gi, "wr_csn_to_wen", wf - cf, (gi == 0) ? 1 : 4);
      check(gi, "wr_blsn", bl, 4'hC);
      check(gi, "wr_d", dv, 16'habcd);
      @(posedge clk); #2;

      // Single read from requester 1.
      xfer(1, 1'b0, 8'h07, 16'h0000, 4'hF, ac, cf, wf, wl, ol, bl, dv, rd);
      check(gi, "rd_ack_cycle", ac, (gi == 0) ? 3 : 8);
      check(gi, "rd_oen_len", ol, (gi == 0) ? 1 : 4);
      check(gi, "rd_data", rd, 16'hba98);
      @(posedge clk); #2;

      // Both requesters held for four transfers.
      we = 2'b01; adr = {8'h33, 8'h44}; wdat = {16'h1111, 16'h2222}; sel = 8'hF5;
      req = 2'b11; n = 0; hi = 0; min_gap = 99; seen_low = 0;
      order.delete();
      while (order.size() < 4 && n < 200) begin
        @(posedge clk); #2; n++;
        if (csn) hi++;
        else begin
          if (seen_low && hi > 0 && hi < min_gap) min_gap = hi;
          seen_low = 1; hi = 0;
        end
        if (ack != '0) order.push_back(ack[1] ? 1 : 0);
        if (order.size() == 4) req = '0;
      end
      req = '0;
      check(gi, "rr_count", order.size(), 4);
      for (int i = 0; i < 4; i++)
        if (i < order.size()) check(gi, "rr_order", order[i], i % 2);
      check(gi, "rr_csn_gap", min_gap, 2);
      @(posedge clk); #2;

      // Requester 0 leaves in its ack cycle as requester 1 arrives.
      we[0] = 1'b0; adr[7:0] = 8'h12; req[0] = 1'b1; n = 0;
      while (!ack[0] && n < 60) begin @(posedge clk); #2; n++; end
      check(gi, "hand_ack0", ack[0], 1);
      req[0] = 1'b0;
      we[1] = 1'b1; adr[15:8] = 8'h5c; wdat[31:16] = 16'h7e81; sel[7:4] = 4'h9; req[1] = 1'b1;
      n = 0;
      do begin @(posedge clk); #2; n++; end while (ack == '0 && n < 60);
      check(gi, "hand_next", ack, 2'b10);
      req[1] = 1'b0;
      @(posedge clk); #2;

      // Reset while the write strobe is active.
      we[0] = 1'b1; adr[7:0] = 8'hc3; wdat[15:0] = 16'h0f0f; sel[3:0] = 4'hF; req[0] = 1'b1;
      n = 0;
      while (wen && n < 60) begin @(posedge clk); #2; n++; end
      check(gi, "mid_in_strobe", wen, 0);
      rst = 1'b1; req = '0;
      @(posedge clk); #2;
      check(gi, "mid_CSN", csn, 1);
      check(gi, "mid_WEN", wen, 1);
      check(gi, "mid_BLSN", blsn, 4'hF);
      check(gi, "mid_busy", busy, 0);
      rst = 1'b0; no_ack = 0;
      repeat (10) begin @(posedge clk); #2; if (ack != '0) no_ack++; end
      check(gi, "mid_no_ack", no_ack, 0);

      // Randomized traffic obeying the hold-until-ack protocol.
      for (int c = 0; c < 400; c++) begin
        @(posedge clk); #2;
        for (int k = 0; k < NREQ; k++) begin
          if ((req[k] && ack[k] && $urandom_range(1, 0) == 1) ||
              (!req[k] && $urandom_range(2, 0) == 0)) begin
            we[k] = 1'($urandom_range(1, 0));
            adr[k*AW +: AW] = AW'($urandom);
            wdat[k*DW +: DW] = DW'($urandom);
            sel[k*4 +: 4] = 4'($urandom);
            req[k] = 1'b1;
          end else if (req[k] && ack[k]) begin
            req[k] = 1'b0;
          end
        end
      end
      n = 0;
      while (req != '0 && n < 100) begin
        @(posedge clk); #2; n++;
        req = req & ~ack;
      end
      check(gi, "drain", req, 0);
      req = '0;
      repeat (4) @(posedge clk);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].done && g_cfg[1].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d cycles required < 20000", t);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
